// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcodes, funct fields and the one-hot select bit order
// used by both the issue stage and the ALU wrapper.
package alu_pkg;

   localparam int ALU_SEL_W = 10;

   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_SLT    = 3'b010;
   localparam logic [2:0] F3_SLTU   = 3'b011;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // Bit positions inside alu_sel; the ALU decodes the same ordering.
   typedef enum logic [3:0] {
      SEL_ADD    = 4'd0,
      SEL_SUB    = 4'd1,
      SEL_MUL    = 4'd2,
      SEL_MULH   = 4'd3,
      SEL_MULHSU = 4'd4,
      SEL_MULHU  = 4'd5,
      SEL_AND    = 4'd6,
      SEL_OR     = 4'd7,
      SEL_SLT    = 4'd8,
      SEL_SLTU   = 4'd9
   } alu_sel_idx_e;

   function automatic logic [ALU_SEL_W-1:0] sel_bit(input alu_sel_idx_e idx);
      logic [ALU_SEL_W-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/operand_forward.sv
// Per-operand bypass mux: x0 reads zero, then EX/MEM, then MEM/WB, then the
// register file.
module operand_forward #(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [WIDTH-1:0]      rf_data,
   input  logic                  exmem_we,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic [WIDTH-1:0]      exmem_data,
   input  logic                  memwb_we,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic [WIDTH-1:0]      memwb_data,
   output logic [WIDTH-1:0]      fwd_data
);

   // rs==0 is tested first, so a producer targeting x0 can never match.
   always_comb begin
      if (rs == '0)
         fwd_data = '0;
      else if (exmem_we && (exmem_rd == rs))
         fwd_data = exmem_data;
      else if (memwb_we && (memwb_rd == rs))
         fwd_data = memwb_data;
      else
         fwd_data = rf_data;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: decodes RV32 ALU ops, resolves forwarding and registers
// operands plus one-hot select into a single handshaked slot feeding the ALU.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [WIDTH-1:0]      in_rs1_data,
   input  logic [WIDTH-1:0]      in_rs2_data,
   input  logic                  fwd_exmem_we,
   input  logic [REG_ADDR_W-1:0] fwd_exmem_rd,
   input  logic [WIDTH-1:0]      fwd_exmem_data,
   input  logic                  fwd_memwb_we,
   input  logic [REG_ADDR_W-1:0] fwd_memwb_rd,
   input  logic [WIDTH-1:0]      fwd_memwb_data,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      operand_a,
   output logic [WIDTH-1:0]      operand_b,
   output logic [ALU_SEL_W-1:0]  alu_sel,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_we,
   output logic                  out_illegal
);

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [REG_ADDR_W-1:0] rd, rs1, rs2;
   logic [WIDTH-1:0]      imm_sext, fwd_a, fwd_b;
   logic [WIDTH-1:0]      dec_a, dec_b;
   logic [ALU_SEL_W-1:0]  dec_sel;
   logic                  dec_legal, dec_we;

   assign opcode   = in_instr[6:0];
   assign rd       = in_instr[7 +: REG_ADDR_W];
   assign funct3   = in_instr[14:12];
   assign rs1      = in_instr[15 +: REG_ADDR_W];
   assign rs2      = in_instr[20 +: REG_ADDR_W];
   assign funct7   = in_instr[31:25];
   assign imm_sext = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};

   operand_forward #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
      .rs(rs1), .rf_data(in_rs1_data),
      .exmem_we(fwd_exmem_we), .exmem_rd(fwd_exmem_rd), .exmem_data(fwd_exmem_data),
      .memwb_we(fwd_memwb_we), .memwb_rd(fwd_memwb_rd), .memwb_data(fwd_memwb_data),
      .fwd_data(fwd_a)
   );

   operand_forward #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
      .rs(rs2), .rf_data(in_rs2_data),
      .exmem_we(fwd_exmem_we), .exmem_rd(fwd_exmem_rd), .exmem_data(fwd_exmem_data),
      .memwb_we(fwd_memwb_we), .memwb_rd(fwd_memwb_rd), .memwb_data(fwd_memwb_data),
      .fwd_data(fwd_b)
   );

   // Every unsupported combination falls through to an all-zero select,
   // which is what marks the instruction illegal.
   always_comb begin
      dec_sel = '0;
      case (opcode)
         OP_REG: begin
            case (funct7)
               F7_BASE: begin
                  case (funct3)
                     F3_ADD:  dec_sel = sel_bit(SEL_ADD);
                     F3_AND:  dec_sel = sel_bit(SEL_AND);
                     F3_OR:   dec_sel = sel_bit(SEL_OR);
                     F3_SLT:  dec_sel = sel_bit(SEL_SLT);
                     F3_SLTU: dec_sel = sel_bit(SEL_SLTU);
                     default: dec_sel = '0;
                  endcase
               end
               F7_ALT: dec_sel = (funct3 == F3_ADD) ? sel_bit(SEL_SUB) : '0;
               F7_MULDIV: begin
                  case (funct3)
                     F3_ADD:  dec_sel = sel_bit(SEL_MUL);
                     F3_MULH: dec_sel = sel_bit(SEL_MULH);
                     F3_SLT:  dec_sel = sel_bit(SEL_MULHSU);
                     F3_SLTU: dec_sel = sel_bit(SEL_MULHU);
                     default: dec_sel = '0;
                  endcase
               end
               default: dec_sel = '0;
            endcase
         end
         OP_IMM: begin
            case (funct3)
               F3_ADD:  dec_sel = sel_bit(SEL_ADD);
               F3_AND:  dec_sel = sel_bit(SEL_AND);
               F3_OR:   dec_sel = sel_bit(SEL_OR);
               F3_SLT:  dec_sel = sel_bit(SEL_SLT);
               F3_SLTU: dec_sel = sel_bit(SEL_SLTU);
               default: dec_sel = '0;
            endcase
         end
         default: dec_sel = '0;
      endcase
   end

   assign dec_legal = |dec_sel;
   assign dec_we    = dec_legal && (rd != '0);
   assign dec_a     = dec_legal ? fwd_a : '0;
   assign dec_b     = !dec_legal ? '0 : ((opcode == OP_IMM) ? imm_sext : fwd_b);

   // Handshake: a beat moves when valid && ready on the same rising edge; valid
   // never waits on ready, and the slot accepts whenever it is empty or draining.
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         operand_a   <= '0;
         operand_b   <= '0;
         alu_sel     <= '0;
         out_rd      <= '0;
         out_we      <= 1'b0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid   <= 1'b1;
         operand_a   <= dec_a;
         operand_b   <= dec_b;
         alu_sel     <= dec_sel;
         out_rd      <= rd;
         out_we      <= dec_we;
         out_illegal <= !dec_legal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
